// File: rtl/yd_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// yd_wb_arbiter_if
// Bus bundle between the execute/load units, the write-back arbiter and the
// 16-entry register file.
//   alu_*            : ALU result handshake (valid/ready, waddr, data)
//   ld_*             : load result handshake (valid/ready, waddr, data)
//   din0/waddr0/we0  : register file write port 0 (ALU path)
//   din1/waddr1/we1  : register file write port 1 (load path)
//   jpc              : bubble / PC-writable strobe
//   drop_cnt         : saturating count of superseded load writes
// Modports: master = producers/consumers around the arbiter, slave = arbiter.
// -----------------------------------------------------------------------------
interface yd_wb_arbiter_if #(
    parameter int CW = 8
);
    logic          alu_valid;
    logic          alu_ready;
    logic [3:0]    alu_waddr;
    logic [15:0]   alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [3:0]    ld_waddr;
    logic [15:0]   ld_data;
    logic [15:0]   din0;
    logic [3:0]    waddr0;
    logic          we0;
    logic [15:0]   din1;
    logic [3:0]    waddr1;
    logic          we1;
    logic          jpc;
    logic [CW-1:0] drop_cnt;

    modport master (
        output alu_valid, alu_waddr, alu_data,
        output ld_valid, ld_waddr, ld_data,
        input  alu_ready, ld_ready,
        input  din0, waddr0, we0, din1, waddr1, we1, jpc, drop_cnt
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_data,
        input  ld_valid, ld_waddr, ld_data,
        output alu_ready, ld_ready,
        output din0, waddr0, we0, din1, waddr1, we1, jpc, drop_cnt
    );
endinterface

// File: rtl/yd_wb_arbiter.sv
// -----------------------------------------------------------------------------
// yd_wb_arbiter
// Write-back stage in front of the register file. ALU results go to write
// port 0 with one cycle of latency; load results are buffered in a small FIFO
// that pops its head every non-empty cycle onto write port 1. A load whose
// head address collides with a same-cycle ALU write is dropped (the load is
// the older write) and counted. Any write to PC (r15) starts a bubble that
// holds jpc high and blocks the ALU path.
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : yd_wb_arbiter_if.slave (ALU/load handshakes, write ports, jpc,
//            drop_cnt)
// Parameters:
//   LD_DEPTH   : load FIFO depth, power of 2, >= 2
//   BUBBLE_CYC : extra jpc cycles after the cycle presenting the PC write
//   CW         : drop counter width
// -----------------------------------------------------------------------------
module yd_wb_arbiter #(
    parameter int LD_DEPTH   = 2,
    parameter int BUBBLE_CYC = 2,
    parameter int CW         = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    yd_wb_arbiter_if.slave bus
);
    localparam int          PW       = $clog2(LD_DEPTH);
    localparam int          CNTW     = PW + 1;
    localparam int          BW       = $clog2(BUBBLE_CYC + 2);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(LD_DEPTH);
    localparam logic [BW-1:0]   BUB_LOAD = BW'(BUBBLE_CYC + 1);
    localparam logic [3:0]  ADDR_ZERO = 4'd0;
    localparam logic [3:0]  ADDR_PC   = 4'd15;

    // load FIFO
    logic [3:0]      r_fifo_addr [LD_DEPTH];
    logic [15:0]     r_fifo_data [LD_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;

    // write ports and status
    logic [15:0]     r_din0;
    logic [3:0]      r_waddr0;
    logic            r_we0;
    logic [15:0]     r_din1;
    logic [3:0]      r_waddr1;
    logic            r_we1;
    logic [BW-1:0]   r_bub_cnt;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_alu_ready;
    logic            w_ld_ready;
    logic            w_alu_hs;
    logic            w_push;
    logic            w_store;
    logic            w_pop;
    logic [3:0]      w_head_addr;
    logic [15:0]     w_head_data;
    logic            w_conflict;
    logic            w_ld_write;
    logic            w_pc_wr;

    // A pending PC write always has a non-zero bubble count, so the bubble
    // counter alone covers both the write cycle and the trailing bubble.
    assign w_alu_ready = (r_bub_cnt == '0);
    assign w_ld_ready  = (r_count != FULL_CNT);

    assign w_alu_hs    = bus.alu_valid && w_alu_ready;
    assign w_push      = bus.ld_valid && w_ld_ready;
    // Loads to the zero register are consumed without taking a FIFO slot.
    assign w_store     = w_push && (bus.ld_waddr != ADDR_ZERO);
    assign w_pop       = (r_count != '0);

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Stored entries never carry address 0, so a match implies a non-zero
    // destination; the explicit check keeps that obvious.
    assign w_conflict  = w_alu_hs && w_pop && (bus.alu_waddr != ADDR_ZERO)
                         && (w_head_addr == bus.alu_waddr);
    assign w_ld_write  = w_pop && !w_conflict;

    assign w_pc_wr     = (w_alu_hs && (bus.alu_waddr == ADDR_PC))
                         || (w_ld_write && (w_head_addr == ADDR_PC));

    // FIFO storage needs no reset: pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_fifo_addr[r_wr_ptr] <= bus.ld_waddr;
            r_fifo_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_din0   <= '0;
            r_waddr0 <= '0;
            r_we0    <= 1'b0;
        end else begin
            r_we0 <= w_alu_hs && (bus.alu_waddr != ADDR_ZERO);
            if (w_alu_hs) begin
                r_din0   <= bus.alu_data;
                r_waddr0 <= bus.alu_waddr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_din1     <= '0;
            r_waddr1   <= '0;
            r_we1      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_we1 <= w_ld_write;
            if (w_pop) begin
                r_din1   <= w_head_data;
                r_waddr1 <= w_head_addr;
            end
            if (w_conflict && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bub_cnt <= '0;
        end else if (w_pc_wr) begin
            r_bub_cnt <= BUB_LOAD;
        end else if (r_bub_cnt != '0) begin
            r_bub_cnt <= r_bub_cnt - BW'(1);
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.din0      = r_din0;
    assign bus.waddr0    = r_waddr0;
    assign bus.we0       = r_we0;
    assign bus.din1      = r_din1;
    assign bus.waddr1    = r_waddr1;
    assign bus.we1       = r_we1;
    assign bus.jpc       = (r_bub_cnt != '0);
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_yd_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_yd_wb_arbiter
// Directed bench for yd_wb_arbiter with LD_DEPTH=2, BUBBLE_CYC=2, CW=8.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_yd_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    yd_wb_arbiter_if #(.CW(8)) bus ();

    yd_wb_arbiter #(
        .LD_DEPTH   (2),
        .BUBBLE_CYC (2),
        .CW         (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_waddr = 4'd0;
        bus.alu_data  = 16'h0000;
        bus.ld_valid  = 1'b0;
        bus.ld_waddr  = 4'd0;
        bus.ld_data   = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.we0, bus.we1, bus.jpc, bus.ld_ready, bus.alu_ready} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_flags: we0/we1/jpc/ld_ready/alu_ready got %b want 00011",
                     {bus.we0, bus.we1, bus.jpc, bus.ld_ready, bus.alu_ready});
        end
        n_checks++;
        if ({bus.din0, bus.waddr0, bus.din1, bus.waddr1, bus.drop_cnt} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: din0=%h waddr0=%0d din1=%h waddr1=%0d drop=%0d want all 0",
                     bus.din0, bus.waddr0, bus.din1, bus.waddr1, bus.drop_cnt);
        end
    endtask

    task automatic test_alu_write();
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd3;
        bus.alu_data  = 16'h1234;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we0, bus.waddr0, bus.din0, bus.we1, bus.jpc} !== {1'b1, 4'd3, 16'h1234, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_write: we0=%b waddr0=%0d din0=%h we1=%b jpc=%b want 1 3 1234 0 0",
                     bus.we0, bus.waddr0, bus.din0, bus.we1, bus.jpc);
        end
        // ALU write to r0 is accepted but not written
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd0;
        bus.alu_data  = 16'hBEEF;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we0, bus.alu_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL alu_r0: we0=%b alu_ready=%b want we0=0 alu_ready=1", bus.we0, bus.alu_ready);
        end
    endtask

    task automatic test_load_stream();
        logic [3:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_waddr = 4'(2 + i);
            bus.ld_data  = 16'(16'h1000 + 2 + i);
            n_checks++;
            if (bus.ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ld_ready_stream[%0d]: got %b want 1", i, bus.ld_ready);
            end
            step();
            if (i >= 1) begin
                exp_addr = 4'(1 + i);
                n_checks++;
                if ({bus.we1, bus.waddr1, bus.din1} !== {1'b1, exp_addr, 16'h1000 + 16'(exp_addr)}) begin
                    n_fail++;
                    $display("FAIL ld_out[%0d]: we1=%b waddr1=%0d din1=%h want 1 %0d %h",
                             i, bus.we1, bus.waddr1, bus.din1, exp_addr, 16'h1000 + 16'(exp_addr));
                end
            end
        end
        // push of a zero-register load is consumed but never written
        bus.ld_waddr = 4'd0;
        bus.ld_data  = 16'hDEAD;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we1, bus.waddr1, bus.din1} !== {1'b1, 4'd4, 16'h1004}) begin
            n_fail++;
            $display("FAIL ld_out_last: we1=%b waddr1=%0d din1=%h want 1 4 1004",
                     bus.we1, bus.waddr1, bus.din1);
        end
        step();
        n_checks++;
        if ({bus.we1, bus.ld_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL ld_r0_drop: we1=%b ld_ready=%b want 0 1", bus.we1, bus.ld_ready);
        end
    endtask

    task automatic test_conflict();
        bus.ld_valid = 1'b1;
        bus.ld_waddr = 4'd5;
        bus.ld_data  = 16'hAAAA;
        step();
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd5;
        bus.alu_data  = 16'h5555;
        n_checks++;
        if (bus.drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL conflict_pre_drop: got %0d want 0", bus.drop_cnt);
        end
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we0, bus.waddr0, bus.din0, bus.we1, bus.drop_cnt} !== {1'b1, 4'd5, 16'h5555, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL conflict: we0=%b waddr0=%0d din0=%h we1=%b drop=%0d want 1 5 5555 0 1",
                     bus.we0, bus.waddr0, bus.din0, bus.we1, bus.drop_cnt);
        end
    endtask

    task automatic test_pc_bubble();
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd15;
        bus.alu_data  = 16'h0040;
        step();
        // hold a new ALU result through the bubble; it must wait
        bus.alu_waddr = 4'd6;
        bus.alu_data  = 16'h6666;
        n_checks++;
        if ({bus.we0, bus.waddr0, bus.din0, bus.jpc, bus.alu_ready} !== {1'b1, 4'd15, 16'h0040, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pc_write: we0=%b waddr0=%0d din0=%h jpc=%b alu_ready=%b want 1 15 0040 1 0",
                     bus.we0, bus.waddr0, bus.din0, bus.jpc, bus.alu_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({bus.we0, bus.jpc, bus.alu_ready} !== 3'b010) begin
                n_fail++;
                $display("FAIL pc_bubble[%0d]: we0=%b jpc=%b alu_ready=%b want 0 1 0",
                         i, bus.we0, bus.jpc, bus.alu_ready);
            end
        end
        step();
        n_checks++;
        if ({bus.we0, bus.jpc, bus.alu_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL pc_bubble_end: we0=%b jpc=%b alu_ready=%b want 0 0 1",
                     bus.we0, bus.jpc, bus.alu_ready);
        end
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we0, bus.waddr0, bus.din0, bus.jpc} !== {1'b1, 4'd6, 16'h6666, 1'b0}) begin
            n_fail++;
            $display("FAIL pc_held_alu: we0=%b waddr0=%0d din0=%h jpc=%b want 1 6 6666 0",
                     bus.we0, bus.waddr0, bus.din0, bus.jpc);
        end
        step();
    endtask

    task automatic test_load_pc_bubble();
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd15;
        bus.alu_data  = 16'h0044;
        step();
        idle_inputs();
        step();
        bus.ld_valid = 1'b1;
        bus.ld_waddr = 4'd15;
        bus.ld_data  = 16'h0080;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.we1, bus.jpc} !== 2'b01) begin
            n_fail++;
            $display("FAIL ldpc_last_bubble: we1=%b jpc=%b want 0 1", bus.we1, bus.jpc);
        end
        step();
        n_checks++;
        if ({bus.we1, bus.waddr1, bus.din1, bus.jpc, bus.alu_ready} !== {1'b1, 4'd15, 16'h0080, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ldpc_write: we1=%b waddr1=%0d din1=%h jpc=%b alu_ready=%b want 1 15 0080 1 0",
                     bus.we1, bus.waddr1, bus.din1, bus.jpc, bus.alu_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({bus.we1, bus.jpc, bus.alu_ready} !== 3'b010) begin
                n_fail++;
                $display("FAIL ldpc_bubble[%0d]: we1=%b jpc=%b alu_ready=%b want 0 1 0",
                         i, bus.we1, bus.jpc, bus.alu_ready);
            end
        end
        step();
        n_checks++;
        if ({bus.jpc, bus.alu_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL ldpc_bubble_end: jpc=%b alu_ready=%b want 0 1", bus.jpc, bus.alu_ready);
        end
    endtask

    task automatic test_drop_saturate();
        // continuous load+ALU to r9: every cycle after the first is a conflict
        bus.ld_valid  = 1'b1;
        bus.ld_waddr  = 4'd9;
        bus.ld_data   = 16'hAAAA;
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd9;
        bus.alu_data  = 16'h5555;
        repeat (10) step();
        n_checks++;
        if ({bus.we0, bus.we1, bus.drop_cnt} !== {1'b1, 1'b0, 8'd10}) begin
            n_fail++;
            $display("FAIL drop_count: we0=%b we1=%b drop=%0d want 1 0 10",
                     bus.we0, bus.we1, bus.drop_cnt);
        end
        repeat (300) step();
        n_checks++;
        if (bus.drop_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d want 255", bus.drop_cnt);
        end
        idle_inputs();
        step();
        n_checks++;
        if ({bus.we0, bus.we1, bus.waddr1, bus.din1, bus.drop_cnt} !== {1'b0, 1'b1, 4'd9, 16'hAAAA, 8'hFF}) begin
            n_fail++;
            $display("FAIL drop_drain: we0=%b we1=%b waddr1=%0d din1=%h drop=%0d want 0 1 9 aaaa 255",
                     bus.we0, bus.we1, bus.waddr1, bus.din1, bus.drop_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int stray;
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 4'd15;
        bus.alu_data  = 16'h0100;
        step();
        idle_inputs();
        bus.ld_valid = 1'b1;
        bus.ld_waddr = 4'd7;
        bus.ld_data  = 16'h7777;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.we0, bus.we1, bus.jpc, bus.ld_ready, bus.alu_ready, bus.drop_cnt} !== {5'b00011, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: we0=%b we1=%b jpc=%b ld_ready=%b alu_ready=%b drop=%0d want 0 0 0 1 1 0",
                     bus.we0, bus.we1, bus.jpc, bus.ld_ready, bus.alu_ready, bus.drop_cnt);
        end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.we1 !== 1'b0 || bus.jpc !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d cycles with we1/jpc high after reset, want 0", stray);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_stream();
        test_conflict();
        test_pc_bubble();
        test_load_pc_bubble();
        test_drop_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1);
    end
endmodule
